// File: rtl/prog_down_timer.sv
// Programmable down-counter/timer with prescaler, latched run mode
// (one-shot, auto-reload, halve) and a registered terminal-count pulse.
module prog_down_timer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      preload,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count_out,
    output logic                  zero,
    output logic                  tc_pulse,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] M_RELOAD = 2'b01;
    localparam logic [1:0] M_HALVE  = 2'b10;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      reload_q, reload_d;
    logic [1:0]            mode_q, mode_d;
    logic [PRESCALE_W-1:0] presc_reg_q, presc_reg_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic                  tc_q, tc_d;

    logic                  tick;
    logic [WIDTH-1:0]      dec;
    logic [WIDTH-1:0]      half;

    assign dec  = count_q - 1'b1;
    assign half = count_q >> 1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            count_q     <= '1;
            reload_q    <= '1;
            mode_q      <= 2'b00;
            presc_reg_q <= '0;
            presc_cnt_q <= '0;
            tc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            presc_reg_q <= presc_reg_d;
            presc_cnt_q <= presc_cnt_d;
            tc_q        <= tc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        mode_d      = mode_q;
        presc_reg_d = presc_reg_q;
        presc_cnt_d = presc_cnt_q;
        tc_d        = 1'b0;
        tick        = 1'b0;

        if (load) begin
            count_d     = preload;
            reload_d    = preload;
            mode_d      = mode;
            presc_reg_d = prescale;
            presc_cnt_d = prescale;
            // A zero preload has nothing to count down in the terminating modes
            if (preload == '0 && mode != M_RELOAD) begin
                state_d = DONE;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN && en) begin
            if (presc_cnt_q == '0) begin
                tick        = 1'b1;
                presc_cnt_d = presc_reg_q;
            end else begin
                presc_cnt_d = presc_cnt_q - 1'b1;
            end

            if (tick) begin
                unique case (1'b1)
                    (mode_q == M_RELOAD): begin
                        if (count_q != '0) begin
                            count_d = dec;
                            tc_d    = (dec == '0);
                        end else if (reload_q == '0) begin
                            tc_d = 1'b1;
                        end else begin
                            count_d = reload_q;
                        end
                    end
                    (mode_q == M_HALVE): begin
                        count_d = half;
                        if (half == '0) begin
                            tc_d    = (count_q != '0);
                            state_d = DONE;
                        end
                    end
                    default: begin
                        count_d = (count_q == '0) ? count_q : dec;
                        if (count_d == '0) begin
                            tc_d    = (count_q != '0);
                            state_d = DONE;
                        end
                    end
                endcase
            end
        end
    end

    assign count_out = count_q;
    assign zero      = (count_q == '0);
    assign tc_pulse  = tc_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_prog_down_timer.sv
// Scoreboard bench for prog_down_timer: 8-bit and 16-bit instances share
// stimulus; each scenario pushes expected outputs and pops them per cycle.
module tb_prog_down_timer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] pre = '0;
    logic [1:0]  md = '0;
    logic [7:0]  ps = '0;

    logic [7:0]  c8;
    logic        z8, tc8, b8;
    logic [15:0] c16;
    logic        z16, tc16, b16;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0] cnt;
        logic        tc;
        logic        busy;
        logic        zero;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    prog_down_timer #(.WIDTH(8), .PRESCALE_W(4)) u8 (
        .clk(clk), .nrst(nrst), .en(en), .load(load),
        .preload(pre[7:0]), .mode(md), .prescale(ps[3:0]),
        .count_out(c8), .zero(z8), .tc_pulse(tc8), .busy(b8)
    );

    prog_down_timer #(.WIDTH(16), .PRESCALE_W(8)) u16 (
        .clk(clk), .nrst(nrst), .en(en), .load(load),
        .preload(pre), .mode(md), .prescale(ps),
        .count_out(c16), .zero(z16), .tc_pulse(tc16), .busy(b16)
    );

    function automatic exp_t mk(logic [15:0] c, logic t, logic b);
        exp_t e;
        e.cnt  = c;
        e.tc   = t;
        e.busy = b;
        e.zero = (c == 16'h0);
        return e;
    endfunction

    function automatic exp_t obs(bit w16);
        exp_t e;
        if (w16) begin
            e.cnt = c16; e.tc = tc16; e.busy = b16; e.zero = z16;
        end else begin
            e.cnt = {8'h00, c8}; e.tc = tc8; e.busy = b8; e.zero = z8;
        end
        return e;
    endfunction

    task automatic test_reset();
        exp_t e, o;
        nrst = 1'b0; en = 1'b1; load = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            q.push_back(mk(16'h00FF, 1'b0, 1'b0));
            q.push_back(mk(16'hFFFF, 1'b0, 1'b0));
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                e = q.pop_front();
                o = obs(w[0]);
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL reset w%0d s%0d: cnt=%h tc=%b busy=%b z=%b expected cnt=%h tc=%b busy=%b z=%b",
                             w, j, o.cnt, o.tc, o.busy, o.zero, e.cnt, e.tc, e.busy, e.zero);
                end
            end
        end
    endtask

    task automatic test_oneshot(input bit w16, input logic [15:0] p);
        exp_t e, o;
        logic [15:0] v;
        logic t;
        int n;
        @(negedge clk);
        pre = p; md = 2'b00; ps = 8'd0; en = 1'b1; load = 1'b1;
        q.push_back(mk(p, 1'b0, 1'b1));
        v = p;
        n = int'(p) + 6;
        @(negedge clk);
        load = 1'b0; pre = 16'h0055; md = 2'b01; ps = 8'd3;
        for (int j = 0; j < n; j++) begin
            e = q.pop_front();
            o = obs(w16);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL oneshot w%0d s%0d: cnt=%h tc=%b busy=%b z=%b expected cnt=%h tc=%b busy=%b z=%b",
                         w16, j, o.cnt, o.tc, o.busy, o.zero, e.cnt, e.tc, e.busy, e.zero);
            end
            if (j < n - 1) begin
                t = 1'b0;
                if (v != 16'h0) begin
                    v = v - 16'h1;
                    t = (v == 16'h0);
                end
                q.push_back(mk(v, t, v != 16'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reload(input bit w16, input int p, input int pscl,
                               input int n, input int drop_at);
        exp_t e, o;
        int k;
        logic t;
        @(negedge clk);
        pre = 16'(p); md = 2'b01; ps = 8'(pscl); en = 1'b1; load = 1'b1;
        q.push_back(mk(16'(p), 1'b0, 1'b1));
        k = 0;
        @(negedge clk);
        load = 1'b0; pre = 16'h00AA; md = 2'b10; ps = 8'd0;
        for (int j = 0; j < n; j++) begin
            e = q.pop_front();
            o = obs(w16);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reload w%0d s%0d: cnt=%h tc=%b busy=%b z=%b expected cnt=%h tc=%b busy=%b z=%b",
                         w16, j, o.cnt, o.tc, o.busy, o.zero, e.cnt, e.tc, e.busy, e.zero);
            end
            if (j < n - 1) begin
                en = !(j >= drop_at && j < drop_at + 5);
                t = 1'b0;
                if (en) begin
                    k++;
                    t = (k % (pscl + 1) == 0) && ((k / (pscl + 1)) % (p + 1) == p);
                end
                q.push_back(mk(16'(p - (k / (pscl + 1)) % (p + 1)), t, 1'b1));
            end
            @(negedge clk);
        end
        en = 1'b1;
    endtask

    task automatic test_halve(input bit w16, input logic [15:0] p,
                              input int pscl, input int n);
        exp_t e, o;
        logic [15:0] v;
        logic t;
        int k;
        @(negedge clk);
        pre = p; md = 2'b10; ps = 8'(pscl); en = 1'b1; load = 1'b1;
        q.push_back(mk(p, 1'b0, 1'b1));
        v = p;
        k = 0;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < n; j++) begin
            e = q.pop_front();
            o = obs(w16);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL halve w%0d s%0d: cnt=%h tc=%b busy=%b z=%b expected cnt=%h tc=%b busy=%b z=%b",
                         w16, j, o.cnt, o.tc, o.busy, o.zero, e.cnt, e.tc, e.busy, e.zero);
            end
            if (j < n - 1) begin
                k++;
                t = 1'b0;
                if (v != 16'h0 && k % (pscl + 1) == 0) begin
                    v = v >> 1;
                    t = (v == 16'h0);
                end
                q.push_back(mk(v, t, v != 16'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back(input bit w16);
        exp_t e, o;
        int ld_t[13] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        int pr_t[13] = '{2, 0, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0};
        int md_t[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0};
        int ec_t[13] = '{2, 1, 7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0};
        int et_t[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
        int eb_t[13] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        @(negedge clk);
        ps = 8'd0; en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            load = ld_t[i][0];
            if (ld_t[i] != 0) begin
                pre = 16'(pr_t[i]);
                md  = 2'(md_t[i]);
            end
            q.push_back(mk(16'(ec_t[i]), et_t[i][0], eb_t[i][0]));
            @(negedge clk);
            load = 1'b0;
            e = q.pop_front();
            o = obs(w16);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL b2b w%0d s%0d: cnt=%h tc=%b busy=%b z=%b expected cnt=%h tc=%b busy=%b z=%b",
                         w16, i, o.cnt, o.tc, o.busy, o.zero, e.cnt, e.tc, e.busy, e.zero);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, o;
        @(negedge clk);
        pre = 16'd100; md = 2'b00; ps = 8'd0; en = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 0) #1;
            else if (s == 1) begin @(posedge clk); #1; end
            else begin
                @(negedge clk);
                nrst = 1'b1;
            end
            q.push_back(mk(16'h00FF, 1'b0, 1'b0));
            q.push_back(mk(16'hFFFF, 1'b0, 1'b0));
            for (int w = 0; w < 2; w++) begin
                e = q.pop_front();
                o = obs(w[0]);
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL async_rst w%0d s%0d: cnt=%h tc=%b busy=%b z=%b expected cnt=%h tc=%b busy=%b z=%b",
                             w, s, o.cnt, o.tc, o.busy, o.zero, e.cnt, e.tc, e.busy, e.zero);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot(1'b0, 16'd5);
        test_reload(1'b0, 3, 2, 40, 14);
        test_halve(1'b0, 16'h00B4, 1, 22);
        test_back_to_back(1'b0);
        test_oneshot(1'b1, 16'd260);
        test_reload(1'b1, 3, 20, 100, 30);
        test_halve(1'b1, 16'hB400, 1, 38);
        test_back_to_back(1'b1);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
